sel_encode_pipe: RTL and testbench
==================================

Name: sel_encode_pipe

Overview:
- Registered, parametrised successor to the combinational select-and-encode stage of the datapath.
- Owns the instruction register (IR). Decodes the Ra/Rb/Rc fields under control-unit selects into one-hot register-file in/out enables.
- Produces the extended immediate (sign or zero) and flags illegal select combinations.
- Sits between the bus (IR load) and the register file / control unit. Adds one pipeline register on all decoded outputs.

Parameters:
- BITS, 32, datapath and IR width.
- REGISTERS, 16, register-file depth; must be a power of 2, at least 2.
- REGISTER_BITS, $clog2(REGISTERS), width of each register field.
- OPCODE_BITS, 5, opcode width at IR MSBs.
- IMM_BITS, BITS-OPCODE_BITS-3*REGISTER_BITS, immediate field width (derived; must be at least 1).
- ZERO_EXT, 0, 1 selects zero extension of the immediate instead of sign extension.

Ports:
- clk  in  1  rising-edge clock.
- clr_n  in  1  asynchronous active-low reset.
- bus_in  in  BITS  bus value captured into IR.
- IRin  in  1  IR load enable.
- Gra, Grb, Grc  in  1 each  field selects.
- Rin, Rout, BAout  in  1 each  enable requests.
- ir_out  out  BITS  current IR contents.
- opcode  out  OPCODE_BITS  IR[BITS-1 -: OPCODE_BITS], unregistered view of IR.
- reg_in_ctrl  out  REGISTERS  one-hot register write enable (registered).
- reg_out_ctrl  out  REGISTERS  one-hot register drive enable (registered).
- base_zero  out  1  BAout selected R0; bus must carry zero (registered).
- c_ext  out  BITS  extended immediate (registered).
- sel_err  out  1  illegal select combination this cycle (registered).
- ctrl_valid  out  1  decoded outputs correspond to a loaded IR (registered).

Behaviour:
- Reset (clr_n low, async): IR=0; reg_in_ctrl, reg_out_ctrl, c_ext = 0; base_zero, sel_err, ctrl_valid = 0. Held while clr_n is low. Reset mid-operation drops all enables the same instant.
- IR: on posedge with IRin=1, IR <= bus_in. ctrl_valid is set on the first IR load after reset and stays set until the next reset.
- IR fields, MSB down: opcode, ra, rb, rc, imm[IMM_BITS-1:0].
- Decode is combinational from the current IR and the select inputs, then registered. Outputs reflect the inputs sampled one cycle earlier (latency 1).
- If IRin and G* are asserted in the same cycle, decode uses the old IR. The new IR affects outputs only from the cycle after next.
- idx = ({RB{Gra}}&ra) | ({RB{Grb}}&rb) | ({RB{Grc}}&rc), where RB = REGISTER_BITS. OR-combination is the defined result when several selects are asserted.
- sel_err <= 1 when more than one of Gra/Grb/Grc is high, or when Rin and Rout are both high. Enables are still generated per the rules below.
- No G asserted: idx=0. An enable request then still targets R0 and sets sel_err.
- reg_in_ctrl <= Rin ? (1<<idx) : 0.
- BAout with idx=0: reg_out_ctrl <= 0 and base_zero <= 1.
- All other (Rout|BAout) cases: reg_out_ctrl <= 1<<idx, base_zero <= 0.
- Neither Rout nor BAout: reg_out_ctrl <= 0, base_zero <= 0.
- c_ext is updated every cycle:
  - ZERO_EXT=0: imm sign-extended to BITS.
  - ZERO_EXT=1: imm zero-extended to BITS.
- reg_in_ctrl and reg_out_ctrl are each zero or exactly one-hot, never multi-bit.

Test Plan:
- Reset: clr_n=0 mid-run with Rin=1 -> all outputs 0 immediately; IR reads 0 after release.
- Load 0x1B069022 (opcode 3, ra=6, rb=0, rc=13, imm=4130) with IRin=1, then Gra=1, Rout=1 -> next cycle reg_out_ctrl=0x0040, c_ext=0x00001022, sel_err=0, ctrl_valid=1.
- Same IR, Grb=1, BAout=1 -> reg_out_ctrl=0x0000, base_zero=1; then Grc=1, BAout=1 -> reg_out_ctrl=0x2000, base_zero=0.
- Grc=1, Rin=1 -> reg_in_ctrl=0x2000. Then Gra=Grc=1, Rin=1 -> idx=6|13=15, reg_in_ctrl=0x8000, sel_err=1. Then Rin=Rout=1 -> sel_err=1.
- imm field 0x4000: ZERO_EXT=0 -> c_ext=0xFFFFC000; ZERO_EXT=1 instance -> c_ext=0x00004000.
- IRin=1 with new IR (ra=2) and Gra=1, Rout=1 in the same cycle -> next cycle reg_out_ctrl=0x0040 (old ra). Holding Gra, Rout -> following cycle 0x0004. Repeat at REGISTERS=32, BITS=64 for field alignment.

Source files
------------

// File: rtl/sel_encode_pipe.sv
// Select-and-encode stage: owns the IR and decodes the Ra/Rb/Rc fields into one-hot
// register-file enables, with an extended immediate and an illegal-select flag, all registered.
module sel_encode_pipe #(
    parameter int BITS          = 32,
    parameter int REGISTERS     = 16,
    parameter int REGISTER_BITS = $clog2(REGISTERS),
    parameter int OPCODE_BITS   = 5,
    parameter int IMM_BITS      = BITS - OPCODE_BITS - 3 * REGISTER_BITS,
    parameter int ZERO_EXT      = 0
) (
    input  logic                   clk,
    input  logic                   clr_n,
    input  logic [BITS-1:0]        bus_in,
    input  logic                   IRin,
    input  logic                   Gra,
    input  logic                   Grb,
    input  logic                   Grc,
    input  logic                   Rin,
    input  logic                   Rout,
    input  logic                   BAout,
    output logic [BITS-1:0]        ir_out,
    output logic [OPCODE_BITS-1:0] opcode,
    output logic [REGISTERS-1:0]   reg_in_ctrl,
    output logic [REGISTERS-1:0]   reg_out_ctrl,
    output logic                   base_zero,
    output logic [BITS-1:0]        c_ext,
    output logic                   sel_err,
    output logic                   ctrl_valid
);

    localparam int RA_LSB = BITS - OPCODE_BITS - REGISTER_BITS;
    localparam int RB_LSB = RA_LSB - REGISTER_BITS;
    localparam int RC_LSB = RB_LSB - REGISTER_BITS;

    logic [BITS-1:0]          ir;
    logic                     ir_loaded;
    logic [REGISTER_BITS-1:0] ra, rb, rc, idx;
    logic [IMM_BITS-1:0]      imm;
    logic [REGISTERS-1:0]     one_hot;
    logic [REGISTERS-1:0]     in_next, out_next;
    logic                     base_zero_next, err_next;
    logic                     multi_sel, no_sel;
    logic [BITS-1:0]          ext_next;

    assign ra     = ir[RA_LSB +: REGISTER_BITS];
    assign rb     = ir[RB_LSB +: REGISTER_BITS];
    assign rc     = ir[RC_LSB +: REGISTER_BITS];
    assign imm    = ir[IMM_BITS-1:0];
    assign opcode = ir[BITS-1 -: OPCODE_BITS];
    assign ir_out = ir;

    // Overlapping selects OR their fields together; with no select the index falls to R0.
    always_comb begin
        idx            = ({REGISTER_BITS{Gra}} & ra)
                       | ({REGISTER_BITS{Grb}} & rb)
                       | ({REGISTER_BITS{Grc}} & rc);
        one_hot        = {{(REGISTERS-1){1'b0}}, 1'b1} << idx;
        multi_sel      = (Gra & Grb) | (Gra & Grc) | (Grb & Grc);
        no_sel         = ~(Gra | Grb | Grc);
        err_next       = multi_sel | (Rin & Rout) | (no_sel & (Rin | Rout | BAout));
        in_next        = Rin ? one_hot : '0;
        out_next       = '0;
        base_zero_next = 1'b0;
        if (BAout && idx == '0) begin
            base_zero_next = 1'b1;
        end else if (Rout || BAout) begin
            out_next = one_hot;
        end
        if (ZERO_EXT != 0) begin
            ext_next = {{(BITS-IMM_BITS){1'b0}}, imm};
        end else begin
            ext_next = {{(BITS-IMM_BITS){imm[IMM_BITS-1]}}, imm};
        end
    end

    // ctrl_valid trails the first load by one edge, when decode first sees the loaded IR.
    always_ff @(posedge clk or negedge clr_n) begin
        if (!clr_n) begin
            ir           <= '0;
            ir_loaded    <= 1'b0;
            reg_in_ctrl  <= '0;
            reg_out_ctrl <= '0;
            base_zero    <= 1'b0;
            c_ext        <= '0;
            sel_err      <= 1'b0;
            ctrl_valid   <= 1'b0;
        end else begin
            if (IRin) begin
                ir <= bus_in;
            end
            ir_loaded    <= ir_loaded | IRin;
            ctrl_valid   <= ir_loaded;
            reg_in_ctrl  <= in_next;
            reg_out_ctrl <= out_next;
            base_zero    <= base_zero_next;
            c_ext        <= ext_next;
            sel_err      <= err_next;
        end
    end

endmodule

// File: tb/tb_sel_encode_pipe.sv
// Directed bench for sel_encode_pipe: default, zero-extending, and 32-register/64-bit instances.
module tb_sel_encode_pipe;

    logic        clk = 1'b0;
    logic        clr_n = 1'b0;
    logic [31:0] bus32 = '0;
    logic [63:0] bus64 = '0;
    logic        IRin = 1'b0, Gra = 1'b0, Grb = 1'b0, Grc = 1'b0;
    logic        Rin = 1'b0, Rout = 1'b0, BAout = 1'b0;

    logic [31:0] ir0, cext0, ir1, cext1;
    logic [4:0]  op0, op1, op2;
    logic [15:0] rin0, rout0, rin1, rout1;
    logic        bz0, err0, val0, bz1, err1, val1;
    logic [63:0] ir2, cext2;
    logic [31:0] rin2, rout2;
    logic        bz2, err2, val2;

    int compared = 0;
    int mismatched = 0;

    always #5 clk = ~clk;

    sel_encode_pipe dut0 (
        .clk(clk), .clr_n(clr_n), .bus_in(bus32), .IRin(IRin),
        .Gra(Gra), .Grb(Grb), .Grc(Grc), .Rin(Rin), .Rout(Rout), .BAout(BAout),
        .ir_out(ir0), .opcode(op0), .reg_in_ctrl(rin0), .reg_out_ctrl(rout0),
        .base_zero(bz0), .c_ext(cext0), .sel_err(err0), .ctrl_valid(val0)
    );

    sel_encode_pipe #(.ZERO_EXT(1)) dut1 (
        .clk(clk), .clr_n(clr_n), .bus_in(bus32), .IRin(IRin),
        .Gra(Gra), .Grb(Grb), .Grc(Grc), .Rin(Rin), .Rout(Rout), .BAout(BAout),
        .ir_out(ir1), .opcode(op1), .reg_in_ctrl(rin1), .reg_out_ctrl(rout1),
        .base_zero(bz1), .c_ext(cext1), .sel_err(err1), .ctrl_valid(val1)
    );

    sel_encode_pipe #(.BITS(64), .REGISTERS(32)) dut2 (
        .clk(clk), .clr_n(clr_n), .bus_in(bus64), .IRin(IRin),
        .Gra(Gra), .Grb(Grb), .Grc(Grc), .Rin(Rin), .Rout(Rout), .BAout(BAout),
        .ir_out(ir2), .opcode(op2), .reg_in_ctrl(rin2), .reg_out_ctrl(rout2),
        .base_zero(bz2), .c_ext(cext2), .sel_err(err2), .ctrl_valid(val2)
    );

    task automatic checkOutput(input string tag, input logic [63:0] observed, input logic [63:0] expected);
        compared++;
        if (observed !== expected) begin
            mismatched++;
            $display("[TB] FAIL %s: observed %h expected %h", tag, observed, expected);
        end
    endtask

    // Drives one cycle of inputs and returns 1 time unit after the capturing edge.
    task automatic applyStimulus(input logic irin, input logic [31:0] b32, input logic [63:0] b64,
                                 input logic ga, input logic gb, input logic gc,
                                 input logic ri, input logic ro, input logic ba);
        IRin = irin; bus32 = b32; bus64 = b64;
        Gra = ga; Grb = gb; Grc = gc; Rin = ri; Rout = ro; BAout = ba;
        @(posedge clk);
        #1;
    endtask

    initial begin
        repeat (2) @(posedge clk);
        #1;
        checkOutput("reset_ir", ir0, 0);
        checkOutput("reset_cext", cext0, 0);
        checkOutput("reset_valid", val0, 0);
        checkOutput("reset_err", err0, 0);
        clr_n = 1'b1;

        applyStimulus(1, 32'h1B069022, {5'd3, 5'd6, 5'd0, 5'd13, 44'h1022}, 0, 0, 0, 0, 0, 0);
        checkOutput("load_ir", ir0, 64'h1B069022);
        checkOutput("load_opcode", op0, 3);

        applyStimulus(0, 32'h0, 64'h0, 1, 0, 0, 0, 1, 0);
        checkOutput("ra_rout", rout0, 16'h0040);
        checkOutput("ra_cext", cext0, 32'h00001022);
        checkOutput("ra_cext_zx", cext1, 32'h00001022);
        checkOutput("ra_err", err0, 0);
        checkOutput("ra_valid", val0, 1);
        checkOutput("ra_rout_w64", rout2, 32'h00000040);
        checkOutput("ra_cext_w64", cext2, 64'h1022);

        applyStimulus(0, 32'h0, 64'h0, 0, 1, 0, 0, 0, 1);
        checkOutput("rb_ba_rout", rout0, 0);
        checkOutput("rb_ba_bz", bz0, 1);
        checkOutput("rb_ba_err", err0, 0);

        applyStimulus(0, 32'h0, 64'h0, 0, 0, 1, 0, 0, 1);
        checkOutput("rc_ba_rout", rout0, 16'h2000);
        checkOutput("rc_ba_bz", bz0, 0);

        applyStimulus(0, 32'h0, 64'h0, 0, 0, 1, 1, 0, 0);
        checkOutput("rc_rin", rin0, 16'h2000);
        checkOutput("rc_rin_rout", rout0, 0);
        checkOutput("rc_rin_err", err0, 0);

        applyStimulus(0, 32'h0, 64'h0, 1, 0, 1, 1, 0, 0);
        checkOutput("multi_rin", rin0, 16'h8000);
        checkOutput("multi_err", err0, 1);

        applyStimulus(0, 32'h0, 64'h0, 0, 0, 1, 1, 1, 0);
        checkOutput("rinrout_err", err0, 1);
        checkOutput("rinrout_rin", rin0, 16'h2000);
        checkOutput("rinrout_rout", rout0, 16'h2000);

        applyStimulus(0, 32'h0, 64'h0, 0, 0, 0, 1, 0, 0);
        checkOutput("nosel_rin", rin0, 16'h0001);
        checkOutput("nosel_err", err0, 1);

        applyStimulus(0, 32'h0, 64'h0, 0, 0, 1, 1, 0, 0);
        checkOutput("pre_reset_rin", rin0, 16'h2000);
        #2 clr_n = 1'b0;
        #1;
        checkOutput("async_rin", rin0, 0);
        checkOutput("async_ir", ir0, 0);
        checkOutput("async_cext", cext0, 0);
        checkOutput("async_valid", val0, 0);
        @(posedge clk);
        #1;
        checkOutput("held_rin", rin0, 0);
        clr_n = 1'b1;
        applyStimulus(0, 32'h0, 64'h0, 0, 0, 0, 0, 0, 0);
        checkOutput("post_reset_ir", ir0, 0);
        checkOutput("post_reset_valid", val0, 0);

        applyStimulus(1, 32'h00004000, {20'd0, 44'h800_0000_0000}, 0, 0, 0, 0, 0, 0);
        applyStimulus(0, 32'h0, 64'h0, 0, 0, 0, 0, 0, 0);
        checkOutput("imm_sext", cext0, 32'hFFFFC000);
        checkOutput("imm_zext", cext1, 32'h00004000);
        checkOutput("imm_sext_w64", cext2, 64'hFFFF_F800_0000_0000);

        applyStimulus(1, 32'h03000000, {5'd0, 5'd6, 54'd0}, 0, 0, 0, 0, 0, 0);
        applyStimulus(1, 32'h01000000, {5'd0, 5'd20, 54'd0}, 1, 0, 0, 0, 1, 0);
        checkOutput("old_ir_rout", rout0, 16'h0040);
        checkOutput("old_ir_rout_w64", rout2, 32'h00000040);
        applyStimulus(0, 32'h0, 64'h0, 1, 0, 0, 0, 1, 0);
        checkOutput("new_ir_rout", rout0, 16'h0004);
        checkOutput("new_ir_rout_w64", rout2, 32'h00100000);
        checkOutput("new_ir_valid_w64", val2, 1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
